// File: rtl/stage_mem_pkg.sv
// Shared definitions for the memory-access stage (RVX_Info):
// memOp field positions, access size codes, bus width, FSM states.
package stage_mem_pkg;

    localparam int RVX_BUS_W = 32;

    localparam int MOP_EN  = 0;
    localparam int MOP_WR  = 1;
    localparam int MOP_F3  = 2;
    localparam int F3_UNS  = 2;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    typedef struct packed {
        logic [7:0]           wdOp;
        logic [RVX_BUS_W-1:0] exRes;
        logic [RVX_BUS_W-1:0] memData;
        logic [RVX_BUS_W-1:0] pcPlus;
        logic [RVX_BUS_W-1:0] imm;
    } wb_t;

endpackage

// File: rtl/stage_mem_lane_align.sv
// Byte-lane steering for stores and lane extraction/extension for loads.
// Offsets below the access size are ignored (H uses addr[1], W uses 0).
module mem_lane_align
    import stage_mem_pkg::*;
(
    input  logic [2:0]           f3_i,
    input  logic [1:0]           addr_lo_i,
    input  logic [RVX_BUS_W-1:0] sdata_i,
    input  logic [RVX_BUS_W-1:0] rdata_i,
    output logic [RVX_BUS_W-1:0] wdata_o,
    output logic [3:0]           be_o,
    output logic [RVX_BUS_W-1:0] ldata_o
);

    logic [1:0]           off;
    logic [RVX_BUS_W-1:0] sh;
    logic                 sgn;

    always_comb begin
        off     = 2'b00;
        wdata_o = sdata_i;
        be_o    = 4'b1111;
        case (f3_i[1:0])
            SZ_B: begin
                off     = addr_lo_i;
                wdata_o = {4{sdata_i[7:0]}};
                be_o    = 4'b0001 << off;
            end
            SZ_H: begin
                off     = {addr_lo_i[1], 1'b0};
                wdata_o = {2{sdata_i[15:0]}};
                be_o    = 4'b0011 << off;
            end
            default: ;
        endcase
    end

    assign sh = rdata_i >> {off, 3'b000};

    always_comb begin
        sgn     = 1'b0;
        ldata_o = sh;
        case (f3_i[1:0])
            SZ_B: begin
                sgn     = sh[7] & ~f3_i[F3_UNS];
                ldata_o = {{24{sgn}}, sh[7:0]};
            end
            SZ_H: begin
                sgn     = sh[15] & ~f3_i[F3_UNS];
                ldata_o = {{16{sgn}}, sh[15:0]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/stage_mem.sv
// Memory-access stage: req/ack data bus FSM plus write-back registers.
// Optional MEM_MISALIGN_TRAP_EN adds misalignOut and suppresses bad accesses.
module stage_mem
    import stage_mem_pkg::*;
#(
    parameter int BUS_W       = RVX_BUS_W,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [4:0]       memOpIn,
    input  logic [7:0]       wdOpIn,
    input  logic [BUS_W-1:0] exResultIn,
    input  logic [BUS_W-1:0] regData2In,
    input  logic [BUS_W-1:0] pcPlusIn,
    input  logic [BUS_W-1:0] immIn,
    output logic             stallOut,
    output logic             dmemReq,
    output logic             dmemWe,
    output logic [BUS_W-1:0] dmemAddr,
    output logic [BUS_W-1:0] dmemWdata,
    output logic [3:0]       dmemBe,
    input  logic             dmemAck,
    input  logic [BUS_W-1:0] dmemRdata,
    output logic [7:0]       wdOpOut,
    output logic [BUS_W-1:0] exResultOut,
    output logic [BUS_W-1:0] memDataOut,
    output logic [BUS_W-1:0] pcPlusOut,
    output logic [BUS_W-1:0] immOut,
    output logic             busErrOut
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic             misalignOut
`endif
);

    state_e           state_q;
    logic [7:0]       cnt_q;
    logic             flushed_q;
    logic             req_q;
    logic             we_q;
    logic [BUS_W-1:0] addr_q;
    logic [BUS_W-1:0] wdata_q;
    logic [3:0]       be_q;
    logic             err_q;
    wb_t              wb_q;
    wb_t              wb_d;

    logic [2:0]       f3;
    logic             memEn;
    logic             isWr;
    logic             misal;
    logic             ackHit;
    logic             tmoHit;
    logic             capture;
    logic [BUS_W-1:0] stData;
    logic [BUS_W-1:0] ldData;
    logic [3:0]       stBe;

    assign memEn = memOpIn[MOP_EN];
    assign isWr  = memOpIn[MOP_WR];
    assign f3    = memOpIn[MOP_F3 +: 3];

`ifdef MEM_MISALIGN_TRAP_EN
    logic mis_q;

    assign misal = memEn &&
        ((f3[1:0] == SZ_H && exResultIn[0]) ||
         (f3[1:0] == SZ_W && exResultIn[1:0] != 2'b00));
    assign misalignOut = mis_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) mis_q <= 1'b0;
        else      mis_q <= (state_q == ST_IDLE) && misal && !flush;
    end
`else
    assign misal = 1'b0;
`endif

    mem_lane_align u_align (
        .f3_i      (f3),
        .addr_lo_i (exResultIn[1:0]),
        .sdata_i   (regData2In),
        .rdata_i   (dmemRdata),
        .wdata_o   (stData),
        .be_o      (stBe),
        .ldata_o   (ldData)
    );

    assign ackHit = (state_q == ST_WAIT) && dmemAck;
    assign tmoHit = (state_q == ST_WAIT) && !dmemAck &&
                    (cnt_q == 8'(ACK_TIMEOUT - 1));

    // Ack and timeout both release the upstream stage on the same edge.
    assign stallOut = (state_q == ST_IDLE) ?
                      (memEn && !flush && !misal) :
                      !(dmemAck || tmoHit);

    assign capture = ((state_q == ST_IDLE) && !memEn && !flush) ||
                     (ackHit && !flush && !flushed_q);

    always_comb begin
        wb_d = '0;
        if (capture) begin
            wb_d.wdOp    = wdOpIn;
            wb_d.exRes   = exResultIn;
            wb_d.pcPlus  = pcPlusIn;
            wb_d.imm     = immIn;
            wb_d.memData = (ackHit && !isWr) ? ldData : '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            flushed_q <= 1'b0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            err_q     <= 1'b0;
            wb_q      <= '0;
        end else begin
            wb_q  <= wb_d;
            err_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    cnt_q     <= '0;
                    flushed_q <= 1'b0;
                    if (memEn && !flush && !misal) begin
                        req_q   <= 1'b1;
                        we_q    <= isWr;
                        addr_q  <= {exResultIn[BUS_W-1:2], 2'b00};
                        wdata_q <= stData;
                        be_q    <= stBe;
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (ackHit || tmoHit) begin
                        req_q     <= 1'b0;
                        flushed_q <= 1'b0;
                        err_q     <= tmoHit;
                        state_q   <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                        if (flush) flushed_q <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign dmemReq     = req_q;
    assign dmemWe      = we_q;
    assign dmemAddr    = addr_q;
    assign dmemWdata   = wdata_q;
    assign dmemBe      = be_q;
    assign busErrOut   = err_q;
    assign wdOpOut     = wb_q.wdOp;
    assign exResultOut = wb_q.exRes;
    assign memDataOut  = wb_q.memData;
    assign pcPlusOut   = wb_q.pcPlus;
    assign immOut      = wb_q.imm;

endmodule

// File: tb/tb_stage_mem.sv
// Self-checking bench for stage_mem: vector table plus scoreboard of
// expected write-back records, with hand sequences for multi-cycle cases.
module tb_stage_mem;
    import stage_mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic [4:0]  memOpIn = '0;
    logic [7:0]  wdOpIn = '0;
    logic [31:0] exResultIn = '0;
    logic [31:0] regData2In = '0;
    logic [31:0] pcPlusIn = '0;
    logic [31:0] immIn = '0;
    logic        dmemAck = 1'b0;
    logic [31:0] dmemRdata = '0;
    logic        stallOut, dmemReq, dmemWe, busErrOut;
    logic [31:0] dmemAddr, dmemWdata;
    logic [3:0]  dmemBe;
    logic [7:0]  wdOpOut;
    logic [31:0] exResultOut, memDataOut, pcPlusOut, immOut;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        misalignOut;
`endif

    stage_mem dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .memOpIn     (memOpIn),
        .wdOpIn      (wdOpIn),
        .exResultIn  (exResultIn),
        .regData2In  (regData2In),
        .pcPlusIn    (pcPlusIn),
        .immIn       (immIn),
        .stallOut    (stallOut),
        .dmemReq     (dmemReq),
        .dmemWe      (dmemWe),
        .dmemAddr    (dmemAddr),
        .dmemWdata   (dmemWdata),
        .dmemBe      (dmemBe),
        .dmemAck     (dmemAck),
        .dmemRdata   (dmemRdata),
        .wdOpOut     (wdOpOut),
        .exResultOut (exResultOut),
        .memDataOut  (memDataOut),
        .pcPlusOut   (pcPlusOut),
        .immOut      (immOut),
        .busErrOut   (busErrOut)
`ifdef MEM_MISALIGN_TRAP_EN
        ,
        .misalignOut (misalignOut)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [4:0]  op;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        int          dly;
        logic [31:0] eAddr;
        logic [3:0]  eBe;
        logic [31:0] eWdata;
        logic [31:0] eMdata;
    } vec_t;

    wb_t  sb_q[$];
    vec_t vt[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    localparam logic [4:0] OP_SB  = 5'b00011;
    localparam logic [4:0] OP_SH  = 5'b00111;
    localparam logic [4:0] OP_SW  = 5'b01011;
    localparam logic [4:0] OP_LB  = 5'b00001;
    localparam logic [4:0] OP_LH  = 5'b00101;
    localparam logic [4:0] OP_LW  = 5'b01001;
    localparam logic [4:0] OP_LBU = 5'b10001;
    localparam logic [4:0] OP_LHU = 5'b10101;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic sb_check(input string nm);
        wb_t e;
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: scoreboard empty", nm);
            return;
        end
        e = sb_q.pop_front();
        chk({nm, " wdOp"},  32'(wdOpOut), 32'(e.wdOp));
        chk({nm, " exRes"}, exResultOut, e.exRes);
        chk({nm, " mdata"}, memDataOut, e.memData);
        chk({nm, " pc"},    pcPlusOut, e.pcPlus);
        chk({nm, " imm"},   immOut, e.imm);
    endtask

    task automatic drive(input logic [4:0] op, input logic [7:0] wd,
                         input logic [31:0] ex, input logic [31:0] d,
                         input logic [31:0] pc, input logic [31:0] imm);
        memOpIn    = op;
        wdOpIn     = wd;
        exResultIn = ex;
        regData2In = d;
        pcPlusIn   = pc;
        immIn      = imm;
    endtask

    task automatic push_wb(input logic [7:0] wd, input logic [31:0] ex,
                           input logic [31:0] md, input logic [31:0] pc,
                           input logic [31:0] imm);
        wb_t e;
        e.wdOp    = wd;
        e.exRes   = ex;
        e.memData = md;
        e.pcPlus  = pc;
        e.imm     = imm;
        sb_q.push_back(e);
    endtask

    task automatic idle_in();
        drive(5'b0, 8'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    endtask

    // Called at a negedge; returns at a negedge with idle inputs.
    task automatic mem_op(input vec_t v, input logic [7:0] wd);
        int bad;
        drive(v.op, wd, v.addr, v.sdata, v.addr + 32'h4, 32'hC0 ^ v.addr);
        #1 chk({v.nm, " stall idle"}, 32'(stallOut), 32'd1);
        push_wb(wd, v.addr, v.eMdata, v.addr + 32'h4, 32'hC0 ^ v.addr);
        @(negedge clk);
        chk({v.nm, " req"},  32'(dmemReq), 32'd1);
        chk({v.nm, " we"},   32'(dmemWe), 32'(v.op[1]));
        chk({v.nm, " addr"}, dmemAddr, v.eAddr);
        chk({v.nm, " be"},   32'(dmemBe), 32'(v.eBe));
        if (v.op[1]) chk({v.nm, " wdata"}, dmemWdata, v.eWdata);
        bad = 0;
        for (int i = 0; i < v.dly; i++) begin
            if (stallOut !== 1'b1 || dmemReq !== 1'b1) bad++;
            @(negedge clk);
        end
        chk({v.nm, " wait held"}, 32'(bad), 32'd0);
        dmemAck   = 1'b1;
        dmemRdata = v.rdata;
        #1 chk({v.nm, " stall ack"}, 32'(stallOut), 32'd0);
        @(negedge clk);
        dmemAck = 1'b0;
        chk({v.nm, " req done"}, 32'(dmemReq), 32'd0);
        sb_check(v.nm);
        idle_in();
    endtask

    initial begin
        int bad;

        vt.push_back('{"SB103", OP_SB, 32'h103, 32'h000000A5, 32'h0, 3,
                       32'h100, 4'b1000, 32'hA5A5A5A5, 32'h0});
        vt.push_back('{"SB100", OP_SB, 32'h100, 32'h12345678, 32'h0, 1,
                       32'h100, 4'b0001, 32'h78787878, 32'h0});
        vt.push_back('{"SH102", OP_SH, 32'h102, 32'h1234BEEF, 32'h0, 0,
                       32'h100, 4'b1100, 32'hBEEFBEEF, 32'h0});
        vt.push_back('{"SW200", OP_SW, 32'h200, 32'hDEADBEEF, 32'h0, 2,
                       32'h200, 4'b1111, 32'hDEADBEEF, 32'h0});
        vt.push_back('{"LB102", OP_LB, 32'h102, 32'h0, 32'h0080FF00, 1,
                       32'h100, 4'b0100, 32'h0, 32'hFFFFFF80});
        vt.push_back('{"LBU102", OP_LBU, 32'h102, 32'h0, 32'h0080FF00, 0,
                       32'h100, 4'b0100, 32'h0, 32'h00000080});
        vt.push_back('{"LH102", OP_LH, 32'h102, 32'h0, 32'h0080FF00, 2,
                       32'h100, 4'b1100, 32'h0, 32'h00000080});
        vt.push_back('{"LH102n", OP_LH, 32'h102, 32'h0, 32'h80010000, 0,
                       32'h100, 4'b1100, 32'h0, 32'hFFFF8001});
        vt.push_back('{"LHU100", OP_LHU, 32'h100, 32'h0, 32'h0080FF00, 0,
                       32'h100, 4'b0011, 32'h0, 32'h0000FF00});
        vt.push_back('{"LH100", OP_LH, 32'h100, 32'h0, 32'h0080FF00, 1,
                       32'h100, 4'b0011, 32'h0, 32'hFFFFFF00});
        vt.push_back('{"LB101", OP_LB, 32'h101, 32'h0, 32'h0080FF00, 0,
                       32'h100, 4'b0010, 32'h0, 32'hFFFFFFFF});
`ifndef MEM_MISALIGN_TRAP_EN
        vt.push_back('{"LW102", OP_LW, 32'h102, 32'h0, 32'h0080FF00, 0,
                       32'h100, 4'b1111, 32'h0, 32'h0080FF00});
`endif

        // Reset
        #2 rst = 1'b0;
        @(negedge clk);
        chk("rst wdOp",  32'(wdOpOut), 32'd0);
        chk("rst exRes", exResultOut, 32'd0);
        chk("rst mdata", memDataOut, 32'd0);
        chk("rst req",   32'(dmemReq), 32'd0);
        chk("rst err",   32'(busErrOut), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // ALU pass-through
        drive(5'b0, 8'h5A, 32'h1234, 32'h9, 32'h1004, 32'h77);
        #1 chk("alu stall", 32'(stallOut), 32'd0);
        push_wb(8'h5A, 32'h1234, 32'h0, 32'h1004, 32'h77);
        @(negedge clk);
        chk("alu req", 32'(dmemReq), 32'd0);
        sb_check("alu");

        // Ack while idle is ignored
        drive(5'b0, 8'h21, 32'hABCD, 32'h0, 32'h2000, 32'h3);
        dmemAck = 1'b1;
        push_wb(8'h21, 32'hABCD, 32'h0, 32'h2000, 32'h3);
        @(negedge clk);
        dmemAck = 1'b0;
        chk("idleack req", 32'(dmemReq), 32'd0);
        sb_check("idleack");
        idle_in();

        foreach (vt[k]) mem_op(vt[k], 8'(8'h80 + k));

        // Timeout on a load
        drive(OP_LW, 8'h33, 32'h300, 32'h0, 32'h304, 32'h1);
        push_wb(8'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        bad = 0;
        for (int i = 0; i < 254; i++) begin
            if (stallOut !== 1'b1 || dmemReq !== 1'b1 || busErrOut !== 1'b0)
                bad++;
            @(negedge clk);
        end
        chk("tmo held", 32'(bad), 32'd0);
        chk("tmo stall rel", 32'(stallOut), 32'd0);
        @(negedge clk);
        chk("tmo err", 32'(busErrOut), 32'd1);
        chk("tmo req", 32'(dmemReq), 32'd0);
        sb_check("tmo");
        drive(5'b0, 8'h44, 32'h55, 32'h0, 32'h60, 32'h7);
        push_wb(8'h44, 32'h55, 32'h0, 32'h60, 32'h7);
        @(negedge clk);
        chk("tmo err pulse", 32'(busErrOut), 32'd0);
        sb_check("tmo resume");
        idle_in();

        // Flush during WAIT of a store
        drive(OP_SW, 8'h66, 32'h40, 32'h55AA, 32'h44, 32'h2);
        push_wb(8'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        flush = 1'b1;
        #1 chk("fl stall", 32'(stallOut), 32'd1);
        @(negedge clk);
        flush = 1'b0;
        chk("fl req held", 32'(dmemReq), 32'd1);
        chk("fl we", 32'(dmemWe), 32'd1);
        @(negedge clk);
        dmemAck = 1'b1;
        #1 chk("fl req at ack", 32'(dmemReq), 32'd1);
        chk("fl wdata", dmemWdata, 32'h000055AA);
        @(negedge clk);
        dmemAck = 1'b0;
        chk("fl req done", 32'(dmemReq), 32'd0);
        sb_check("flwait");
        idle_in();

        // Flush in IDLE with a memory op
        drive(OP_LW, 8'h77, 32'h80, 32'h0, 32'h84, 32'h5);
        flush = 1'b1;
        #1 chk("flidle stall", 32'(stallOut), 32'd0);
        push_wb(8'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        flush = 1'b0;
        chk("flidle req", 32'(dmemReq), 32'd0);
        sb_check("flidle");
        idle_in();

`ifdef MEM_MISALIGN_TRAP_EN
        drive(OP_LW, 8'h66, 32'h102, 32'h0, 32'h106, 32'h1);
        #1 chk("mis stall", 32'(stallOut), 32'd0);
        push_wb(8'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("mis pulse", 32'(misalignOut), 32'd1);
        chk("mis req", 32'(dmemReq), 32'd0);
        sb_check("mis");
        idle_in();
        push_wb(8'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("mis end", 32'(misalignOut), 32'd0);
        sb_check("mis idle");
`endif

        // Reset in WAIT drops the request immediately
        drive(OP_LW, 8'h12, 32'h10, 32'h0, 32'h14, 32'h0);
        @(negedge clk);
        chk("rstw req", 32'(dmemReq), 32'd1);
        rst = 1'b0;
        #1 chk("rstw drop", 32'(dmemReq), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        drive(5'b0, 8'h9C, 32'hFACE, 32'h0, 32'h8, 32'h9);
        push_wb(8'h9C, 32'hFACE, 32'h0, 32'h8, 32'h9);
        @(negedge clk);
        sb_check("post rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/stage_mem.md
Name: stage_mem

Overview:
- Memory-access pipeline stage, directly downstream of the execute stage, upstream of write-back.
- Consumes the execute stage's registered outputs and turns load/store ops into req/ack transactions on the data-memory bus.
- Stalls upstream while a transaction is outstanding and handles store byte-lane steering and load extraction/extension.
- Registers the stage results to write-back.

Parameters:
- BUS_W, 32: datapath width; byte-lane logic is defined for 32 only.
- ACK_TIMEOUT, 255: max WAIT cycles before a transaction is aborted; 8-bit counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous squash of the current stage contents
- memOpIn  in  5  [0] memEn, [1] write, [4:2] funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
- wdOpIn  in  8  write-back control, passed through
- exResultIn  in  BUS_W  ALU result; this is the address for memory ops
- regData2In  in  BUS_W  store data
- pcPlusIn  in  BUS_W  passed through
- immIn  in  BUS_W  passed through
- stallOut  out  1  upstream must hold its registers
- dmemReq  out  1  bus request
- dmemWe  out  1  bus write enable
- dmemAddr  out  BUS_W  word-aligned address
- dmemWdata  out  BUS_W  lane-steered store data
- dmemBe  out  4  byte enables
- dmemAck  in  1  one-cycle completion strobe
- dmemRdata  in  BUS_W  read data, valid with dmemAck
- wdOpOut  out  8  registered to write-back
- exResultOut  out  BUS_W  registered to write-back
- memDataOut  out  BUS_W  extended load data
- pcPlusOut  out  BUS_W  registered to write-back
- immOut  out  BUS_W  registered to write-back
- busErrOut  out  1  one-cycle pulse on timeout

Behaviour:
- Reset (rst low, async):
  - All registered outputs are 0.
  - dmemReq = 0, state = IDLE, timeout count = 0, flushed flag = 0.
- States:
  - IDLE, WAIT.
- IDLE, memEn=0:
  - One-cycle pass-through. Outputs capture inputs on the next edge.
  - memDataOut = 0. stallOut = 0.
- IDLE, memEn=1, flush=0:
  - stallOut = 1 combinationally.
  - On the edge: latch dmemAddr = {exResultIn[31:2],2'b00}, dmemWe, dmemBe, dmemWdata; set dmemReq = 1; go to WAIT.
  - Pipeline outputs load a bubble (wdOpOut = 0, other outputs 0).
- WAIT:
  - dmemReq and all bus signals are held stable. stallOut = 1 until dmemAck.
  - In the ack cycle stallOut = 0, so the upstream stage advances on the same edge.
  - On the ack edge: dmemReq = 0, go to IDLE, outputs capture the held inputs, memDataOut = extracted load data (0 for stores).
- Minimum latency: a memory op takes 2 cycles from IDLE entry to write-back output with a same-cycle ack in WAIT.
- Store lanes, off = addr[1:0]:
  - B: wdata = {4{d[7:0]}}, be = 0001<<off.
  - H: wdata = {2{d[15:0]}}, be = 0011<<off.
  - W: wdata = d, be = 1111.
- Load:
  - Shift rdata right by off*8.
  - B/H are sign-extended; BU/HU are zero-extended; W is used unchanged.
- Timeout:
  - The counter increments each WAIT cycle without ack.
  - On reaching ACK_TIMEOUT: drop dmemReq, busErrOut pulses 1 cycle, go to IDLE, outputs get a bubble, stallOut = 0 that cycle.
- flush:
  - In IDLE: all outputs load 0 and no request is issued.
  - In WAIT: the transaction is never aborted; the flushed flag is set, and on completion the outputs get a bubble.
  - Flush also clears the flag on IDLE return.
- dmemAck in IDLE is ignored.
- Reset mid-WAIT drops dmemReq immediately.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined:
  - Adds port misalignOut (out, 1).
  - A misaligned H (addr[0]=1) or W (addr[1:0]≠0) issues no request and stays 1 cycle in IDLE (stallOut = 0).
  - misalignOut pulses 1 on the output edge; wdOpOut = 0.
- Undefined:
  - Low address bits beyond the access size are ignored (forced aligned: H uses addr[1], W uses offset 0).
  - No port is added.

Decomposition:
- Shared package/include (RVX_Info): memOp bit positions, funct3 size codes, BUS_W, FSM state encodings.
- One sub-module, mem_lane_align: combinational store steering plus load extraction/extension.
- The FSM and the pipeline registers stay in stage_mem.

Test Plan:
- ALU op, memEn=0, exResultIn=0x1234 → next edge exResultOut=0x1234, stallOut never high, no dmemReq.
- SB d=0x000000A5 addr=0x103, ack 3 cycles later → dmemBe=1000, dmemWdata=0xA5A5A5A5, dmemAddr=0x100, stallOut high until the ack cycle.
- LB addr=0x102, rdata=0x0080FF00 → memDataOut=0xFFFFFF80; same with LBU → 0x00000080; LH addr=0x102 → 0x00000080.
- Load with no ack for ACK_TIMEOUT cycles → busErrOut single pulse, dmemReq low, wdOpOut=0, pipeline resumes.
- Flush asserted during WAIT of a SW → request held to ack, bus write completes, output bubble (wdOpOut=0).
- With MEM_MISALIGN_TRAP_EN, LW addr=0x102 → misalignOut=1, no dmemReq, wdOpOut=0; without it → dmemAddr=0x100, dmemBe=1111.
